pwm_cmd_decoder: RTL
====================

Name: pwm_cmd_decoder

Overview:
- Byte-stream command parser that sits directly upstream of the PWM channel cores.
- Receives framed configuration commands from the serial/SPI byte receiver.
- Validates each frame, then atomically loads period, on-time and enable for one channel, or for all channels by broadcast.
- Outputs drive the period/tOn/enable inputs of CHANNELS PWM cores.

Parameters:
CHANNELS, 4, number of PWM channels served (1..254)
TIMEOUT, 1000, max clk cycles between bytes of one frame before abort
DEFAULT_PERIOD, 2000, period value loaded into every channel at reset

Ports:
clk  input  1  system clock (same 1 us clock as the PWM cores)
reset  input  1  asynchronous, active-low reset
rx_data  input  8  received byte
rx_valid  input  1  one-cycle strobe; rx_data valid when high
period_out  output  16*CHANNELS  channel n period at bits [16n+15:16n]
ton_out  output  8*CHANNELS  channel n on-time at bits [8n+7:8n]
enable_out  output  CHANNELS  channel n enable at bit n
frame_ok  output  1  one-cycle pulse on successful commit
frame_err  output  1  one-cycle pulse on rejected or aborted frame
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (reset=0, async) forces:
  - every period_out field = DEFAULT_PERIOD
  - ton_out = 0, enable_out = 0
  - frame_ok = 0, frame_err = 0, busy = 0
  - state = IDLE, timeout counter = 0, shadow registers = 0
- Reset asserted mid-frame discards the partial frame; no commit.
- Frame format, 7 bytes: 0xA5, CH, PER_H, PER_L, TON, FLAGS, CHK.
  - CHK = XOR of CH, PER_H, PER_L, TON, FLAGS.
  - FLAGS bit0 = enable; bits 7:1 ignored but included in CHK.
- State machine advances only on rx_valid=1: IDLE -> S_CH -> S_PERH -> S_PERL -> S_TON -> S_FLAGS -> S_CHK -> IDLE.
  - IDLE: 0xA5 -> S_CH; any other byte is ignored silently, no error.
  - S_CH through S_FLAGS: each byte is captured into a shadow register and XORed into a running checksum.
  - A byte of 0xA5 received mid-frame is ordinary data; there is no resync.
  - S_CHK: the byte is compared against the running XOR; state returns to IDLE regardless of outcome.
- Commit conditions, all checked on the CHK byte:
  - checksum matches
  - CH < CHANNELS, or CH = 0xFF (broadcast)
  - {PER_H,PER_L} != 0
- On commit:
  - Target channel (or all channels if broadcast) loads period, ton and enable at the clk edge ending the CHK rx_valid cycle.
  - frame_ok is high for exactly the cycle following that edge.
  - All fields of a channel update on the same edge; partial updates never occur.
- On any commit-condition failure:
  - no output register changes
  - frame_err pulses one cycle, same timing as frame_ok
- TON is passed through unmodified, including TON >= period; saturation is the PWM core's concern.
- Timeout:
  - Counter clears on every rx_valid and while in IDLE.
  - Counter increments each cycle while busy with no rx_valid.
  - When the counter reaches TIMEOUT: state -> IDLE, shadow registers are discarded, frame_err pulses one cycle.
  - If rx_valid coincides with the expiry cycle, the byte wins: it is processed and the counter clears; no timeout fires.
- Counter width: ceil(log2(TIMEOUT+1)); it never wraps because it stops at TIMEOUT.
- busy = (state != IDLE), registered.
- frame_ok and frame_err are never high in the same cycle.
- Back-to-back frames with no idle cycles between them are accepted; the header may arrive on the cycle after the CHK byte.

Test Plan:
- Reset: hold reset=0 for 5 cycles -> all periods = 2000, ton = 0, enable = 0, busy = 0; release, then send no bytes -> outputs unchanged.
- Valid write: send A5 02 07 D0 64 01 B0 (CHK = 02^07^D0^64^01 = B0) -> one cycle later ch2 period=2000, ton=100, enable=1; frame_ok pulses once; ch0, ch1, ch3 unchanged.
- Bad checksum: same frame with CHK=B1 -> frame_err pulses once; all outputs unchanged; busy = 0 after the CHK byte.
- Range/zero: CH=04 with CHANNELS=4 and valid CHK -> frame_err, no change; PER=0000 with valid CHK -> frame_err, no change.
- Broadcast plus back-to-back: A5 FF 03 E8 32 01 CHK immediately followed by a ch1 frame with ton=10 -> all channels period=1000, ton=50, enable=1; then ch1 ton=10; two frame_ok pulses.
- Timeout: send A5 01, then idle TIMEOUT cycles -> frame_err on expiry, busy drops; byte arriving exactly on the expiry cycle -> no timeout, frame continues; garbage bytes in IDLE -> no error.

Source files
------------

// File: rtl/pwm_cmd_decoder.sv
// Parses 7-byte A5-framed PWM config commands and atomically loads period/ton/enable per channel or broadcast.
// Commit lands on the edge ending the CHK byte; frame_ok/frame_err pulse the following cycle.
module pwm_cmd_decoder #(
  parameter int CHANNELS       = 4,
  parameter int TIMEOUT        = 1000,
  parameter int DEFAULT_PERIOD = 2000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [16*CHANNELS-1:0]  period_out,
  output logic [8*CHANNELS-1:0]   ton_out,
  output logic [CHANNELS-1:0]     enable_out,
  output logic                    frame_ok,
  output logic                    frame_err,
  output logic                    busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [8:0] CH_LIM = 9'(CHANNELS);

  typedef enum logic [2:0] {
    IDLE, S_CH, S_PERH, S_PERL, S_TON, S_FLAGS, S_CHK
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [7:0]         ch_q, ch_d;
  logic [7:0]         perh_q, perh_d;
  logic [7:0]         perl_q, perl_d;
  logic [7:0]         tsh_q, tsh_d;
  logic               ensh_q, ensh_d;
  logic [7:0]         xor_q, xor_d;
  logic               ok_q, ok_d;
  logic               err_q, err_d;
  logic               busy_q;
  logic [16*CHANNELS-1:0] period_q;
  logic [8*CHANNELS-1:0]  ton_q;
  logic [CHANNELS-1:0]    enable_q;
  logic [CHANNELS-1:0]    load;
  logic                   commit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    perh_d  = perh_q;
    perl_d  = perl_q;
    tsh_d   = tsh_q;
    ensh_d  = ensh_q;
    xor_d   = xor_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    commit  = 1'b0;
    if (state_q == IDLE) begin
      cnt_d = '0;
      if (rx_valid && rx_data == 8'hA5) begin
        state_d = S_CH;
        xor_d   = 8'h00;
      end
    end else if (rx_valid) begin
      // A received byte always beats a coincident timeout expiry.
      cnt_d = '0;
      if (state_q != S_CHK) xor_d = xor_q ^ rx_data;
      case (state_q)
        S_CH:    begin ch_d   = rx_data;    state_d = S_PERH;  end
        S_PERH:  begin perh_d = rx_data;    state_d = S_PERL;  end
        S_PERL:  begin perl_d = rx_data;    state_d = S_TON;   end
        S_TON:   begin tsh_d  = rx_data;    state_d = S_FLAGS; end
        S_FLAGS: begin ensh_d = rx_data[0]; state_d = S_CHK;   end
        S_CHK: begin
          state_d = IDLE;
          if (rx_data == xor_q && ({1'b0, ch_q} < CH_LIM || ch_q == 8'hFF)
              && {perh_q, perl_q} != 16'h0000) begin
            commit = 1'b1;
            ok_d   = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (cnt_q == CW'(TIMEOUT)) begin
      state_d = IDLE;
      cnt_d   = '0;
      err_d   = 1'b1;
      ch_d    = '0;
      perh_d  = '0;
      perl_d  = '0;
      tsh_d   = '0;
      ensh_d  = 1'b0;
      xor_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    load = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (commit && (ch_q == 8'hFF || ch_q == 8'(c))) load[c] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ch_q     <= '0;
      perh_q   <= '0;
      perl_q   <= '0;
      tsh_q    <= '0;
      ensh_q   <= 1'b0;
      xor_q    <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      ton_q    <= '0;
      enable_q <= '0;
      for (int c = 0; c < CHANNELS; c++) period_q[16*c +: 16] <= 16'(DEFAULT_PERIOD);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      perh_q  <= perh_d;
      perl_q  <= perl_d;
      tsh_q   <= tsh_d;
      ensh_q  <= ensh_d;
      xor_q   <= xor_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      busy_q  <= (state_d != IDLE);
      for (int c = 0; c < CHANNELS; c++) begin
        if (load[c]) begin
          period_q[16*c +: 16] <= {perh_q, perl_q};
          ton_q[8*c +: 8]      <= tsh_q;
          enable_q[c]          <= ensh_q;
        end
      end
    end
  end

  assign period_out = period_q;
  assign ton_out    = ton_q;
  assign enable_out = enable_q;
  assign frame_ok   = ok_q;
  assign frame_err  = err_q;
  assign busy       = busy_q;

endmodule
